// File: rtl/pb_uart_port_arbiter.sv
// Round-robin arbiter sharing one PicoBlaze-style UART register bank between two req/ack masters.
// Optional macro PB_UART_ARB_LOCK_EN lets a requester hold the grant across back-to-back accesses.
module pb_uart_port_arbiter #(
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter logic [7:0] PARK_ADDRESS = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] addr_a,
  input  logic [7:0] wdata_a,
  input  logic       lock_a,
  output logic       ack_a,
  output logic [7:0] rdata_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata_b,
  input  logic       lock_b,
  output logic       ack_b,
  output logic [7:0] rdata_b,
  output logic [7:0] port_id,
  output logic [7:0] data_out,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] read_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t     state, state_next;
  logic       gnt;          // 0 = requester A, 1 = requester B
  logic       last_grant;
  logic       lat_we, lat_win;
  logic       grant_valid, grant_sel;
  logic       sel_we, sel_win;
  logic [7:0] sel_addr, sel_wdata;

  logic [7:0] port_id_nxt, data_out_nxt, rdata_a_nxt, rdata_b_nxt;
  logic       write_strobe_nxt, read_strobe_nxt, ack_a_nxt, ack_b_nxt, busy_nxt;

  // Offset arithmetic wraps, so the window test is a single unsigned compare.
  function automatic logic in_window(input logic [7:0] addr);
    logic [7:0] offset;
    offset = addr - BASE_ADDRESS;
    return offset < 8'd7;
  endfunction

`ifdef PB_UART_ARB_LOCK_EN
  logic lock_hold, lock_owner;
`else
  logic unused_lock;
  assign unused_lock = lock_a | lock_b;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_valid = req_a | req_b;
    grant_sel   = req_b & (~req_a | ~last_grant);
`ifdef PB_UART_ARB_LOCK_EN
    if (lock_hold) begin
      grant_valid = lock_owner ? req_b : req_a;
      grant_sel   = lock_owner;
    end
`endif
  end

  assign sel_we    = grant_sel ? we_b    : we_a;
  assign sel_addr  = grant_sel ? addr_b  : addr_a;
  assign sel_wdata = grant_sel ? wdata_b : wdata_a;
  assign sel_win   = in_window(sel_addr);

  // NOTE: sequential state is assigned non-blocking so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = lat_we ? ACK : CAPTURE;
      CAPTURE: state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus values are computed one cycle ahead and registered, so the window address
  // appears on port_id for exactly the ISSUE cycle.
  always_comb begin
    port_id_nxt      = PARK_ADDRESS;
    write_strobe_nxt = 1'b0;
    read_strobe_nxt  = 1'b0;
    ack_a_nxt        = 1'b0;
    ack_b_nxt        = 1'b0;
    data_out_nxt     = data_out;
    rdata_a_nxt      = rdata_a;
    rdata_b_nxt      = rdata_b;
    busy_nxt         = (state_next != IDLE);
    case (state)
      IDLE: begin
        if (grant_valid && sel_win) begin
          port_id_nxt      = sel_addr;
          write_strobe_nxt = sel_we;
          read_strobe_nxt  = ~sel_we;
          if (sel_we) data_out_nxt = sel_wdata;
        end
      end
      ISSUE: begin
        if (lat_we) begin
          ack_a_nxt = ~gnt;
          ack_b_nxt = gnt;
        end
      end
      CAPTURE: begin
        if (gnt) rdata_b_nxt = lat_win ? read_data : 8'h00;
        else     rdata_a_nxt = lat_win ? read_data : 8'h00;
        ack_a_nxt = ~gnt;
        ack_b_nxt = gnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_id      <= PARK_ADDRESS;
      data_out     <= 8'h00;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      rdata_a      <= 8'h00;
      rdata_b      <= 8'h00;
      busy         <= 1'b0;
    end else begin
      port_id      <= port_id_nxt;
      data_out     <= data_out_nxt;
      write_strobe <= write_strobe_nxt;
      read_strobe  <= read_strobe_nxt;
      ack_a        <= ack_a_nxt;
      ack_b        <= ack_b_nxt;
      rdata_a      <= rdata_a_nxt;
      rdata_b      <= rdata_b_nxt;
      busy         <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_win    <= 1'b0;
`ifdef PB_UART_ARB_LOCK_EN
      lock_hold  <= 1'b0;
      lock_owner <= 1'b0;
`endif
    end else begin
      if (state == IDLE && grant_valid) begin
        gnt     <= grant_sel;
        lat_we  <= sel_we;
        lat_win <= sel_win;
      end
      if (state == ACK) begin
        last_grant <= gnt;
`ifdef PB_UART_ARB_LOCK_EN
        lock_hold  <= gnt ? lock_b : lock_a;
        lock_owner <= gnt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pb_uart_port_arbiter.sv
// Randomized bench for pb_uart_port_arbiter: two requester agents, a register-bank model,
// and a transaction-level reference that predicts every bus cycle from the arbitration rules.
module tb_pb_uart_port_arbiter;

  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] PARK = 8'hFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, we_a, lock_a, ack_a;
  logic       req_b, we_b, lock_b, ack_b;
  logic [7:0] addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
  logic [7:0] port_id, data_out, read_data;
  logic       write_strobe, read_strobe, busy;

  always #5 clk = ~clk;

  pb_uart_port_arbiter #(.BASE_ADDRESS(BASE), .PARK_ADDRESS(PARK)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .lock_a(lock_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .lock_b(lock_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .port_id(port_id), .data_out(data_out), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .read_data(read_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int raise_pct = 0;

  logic [7:0] bank [256];
  logic [7:0] model_mem [256];
  logic [7:0] rd_next;

  // Reference state: the single in-flight access and when its events fall.
  bit         cur_valid, cur_who, cur_we, cur_win;
  logic [7:0] cur_addr, cur_wdata;
  int         cur_g, cur_ack, next_free;
  bit         last_who;
  logic [7:0] exp_dout;
  logic [7:0] exp_rdata [2];
`ifdef PB_UART_ARB_LOCK_EN
  bit cur_lock, lk_hold, lk_owner;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [7:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 6);
  endfunction

  task automatic new_fields(output logic we, output logic [7:0] addr,
                            output logic [7:0] wdata, output logic lock);
    int r;
    r     = $urandom_range(0, 9);
    addr  = (r < 7) ? BASE + 8'(r) : (r == 7) ? 8'h07 : (r == 8) ? 8'h40 : 8'hFF;
    we    = 1'($urandom_range(0, 1));
    wdata = 8'($urandom_range(0, 255));
    lock  = ($urandom_range(0, 3) == 0);
  endtask

  task automatic reset_model();
    cur_valid    = 1'b0;
    next_free    = 0;
    last_who     = 1'b1;
    exp_dout     = 8'h00;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    req_a        = 1'b0;
    req_b        = 1'b0;
`ifdef PB_UART_ARB_LOCK_EN
    lk_hold  = 1'b0;
    lk_owner = 1'b0;
`endif
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_port_id"}, port_id, PARK);
    check({pfx, "_data_out"}, data_out, 8'h00);
    check({pfx, "_wstrobe"}, write_strobe, 1'b0);
    check({pfx, "_rstrobe"}, read_strobe, 1'b0);
    check({pfx, "_ack_a"}, ack_a, 1'b0);
    check({pfx, "_ack_b"}, ack_b, 1'b0);
    check({pfx, "_rdata_a"}, rdata_a, 8'h00);
    check({pfx, "_rdata_b"}, rdata_b, 8'h00);
    check({pfx, "_busy"}, busy, 1'b0);
  endtask

  task automatic check_cycle();
    bit strobe_now, ack_now;
    strobe_now = cur_valid && (cyc == cur_g) && cur_win;
    ack_now    = cur_valid && (cyc == cur_ack);
    if (strobe_now && cur_we) begin
      exp_dout           = cur_wdata;
      model_mem[cur_addr] = cur_wdata;
    end
    if (ack_now && !cur_we) exp_rdata[cur_who] = cur_win ? model_mem[cur_addr] : 8'h00;
    check("port_id", port_id, strobe_now ? cur_addr : PARK);
    check("write_strobe", write_strobe, strobe_now && cur_we);
    check("read_strobe", read_strobe, strobe_now && !cur_we);
    check("data_out", data_out, exp_dout);
    check("ack_a", ack_a, ack_now && !cur_who);
    check("ack_b", ack_b, ack_now && cur_who);
    check("rdata_a", rdata_a, exp_rdata[0]);
    check("rdata_b", rdata_b, exp_rdata[1]);
    check("busy", busy, cur_valid && (cyc >= cur_g) && (cyc <= cur_ack));
  endtask

  // Register-bank model: registered read of whatever port_id shows this cycle.
  task automatic bank_update();
    rd_next = bank[port_id];
    if (write_strobe) bank[port_id] = data_out;
  endtask

  task automatic agents();
    if (req_a && ack_a) req_a = 1'b0;
    else if (!req_a && $urandom_range(1, 100) <= raise_pct) begin
      new_fields(we_a, addr_a, wdata_a, lock_a);
      req_a = 1'b1;
    end
    if (req_b && ack_b) req_b = 1'b0;
    else if (!req_b && $urandom_range(1, 100) <= raise_pct) begin
      new_fields(we_b, addr_b, wdata_b, lock_b);
      req_b = 1'b1;
    end
  endtask

  // Decide the grant taken at the coming edge from the request levels now driven.
  task automatic arbitrate();
    int e;
    bit ra, rb, who;
    e  = cyc + 1;
    ra = req_a;
    rb = req_b;
    if (e < next_free) return;
`ifdef PB_UART_ARB_LOCK_EN
    if (lk_hold) begin
      if (lk_owner) ra = 1'b0;
      else          rb = 1'b0;
    end
`endif
    if (!(ra || rb)) return;
    who       = (ra && rb) ? !last_who : rb;
    cur_valid = 1'b1;
    cur_who   = who;
    cur_we    = who ? we_b : we_a;
    cur_addr  = who ? addr_b : addr_a;
    cur_wdata = who ? wdata_b : wdata_a;
    cur_win   = in_win(cur_addr);
    cur_g     = e;
    cur_ack   = e + (cur_we ? 1 : 2);
    next_free = e + (cur_we ? 3 : 4);
    last_who  = who;
`ifdef PB_UART_ARB_LOCK_EN
    cur_lock = who ? lock_b : lock_a;
    lk_hold  = cur_lock;
    lk_owner = who;
`endif
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    bank_update();
    agents();
    arbitrate();
    @(posedge clk);
    cyc++;
    #1 read_data = rd_next;
  endtask

  task automatic run_op(input bit who, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic lock);
    if (who) begin we_b = we; addr_b = addr; wdata_b = wdata; lock_b = lock; req_b = 1'b1; end
    else     begin we_a = we; addr_a = addr; wdata_a = wdata; lock_a = lock; req_a = 1'b1; end
    for (int i = 0; i < 12; i++) begin
      step();
      if (!(who ? req_b : req_a)) break;
    end
    check("op_done", who ? req_b : req_a, 1'b0);
  endtask

  initial begin
    int start;
    for (int i = 0; i < 256; i++) begin
      bank[i]      = 8'($urandom_range(0, 255));
      model_mem[i] = bank[i];
    end
    bank[2] = 8'h15;
    model_mem[2] = 8'h15;
    reset = 1'b0;
    {we_a, lock_a, we_b, lock_b} = '0;
    {addr_a, wdata_a, addr_b, wdata_b, read_data} = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 check_reset_values("por");
    @(posedge clk);
    #2 reset = 1'b1;

    // Directed accesses: write, read with bank data 8'h15, out-of-window read.
    run_op(1'b0, 1'b1, BASE + 8'd5, 8'h34, 1'b0);
    run_op(1'b1, 1'b0, BASE + 8'd2, 8'h00, 1'b0);
    run_op(1'b0, 1'b0, 8'h40, 8'h00, 1'b0);

    // Continuous contention, then mixed random traffic.
    raise_pct = 100;
    repeat (30) step();
    raise_pct = 35;
    repeat (600) step();
    raise_pct = 0;
    repeat (30) step();
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) step();

    // Reset while a read sits in CAPTURE.
    start = cyc;
    we_a = 1'b0; addr_a = BASE + 8'd3; lock_a = 1'b0; req_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cur_valid && cur_g > start && cyc == cur_g + 1) break;
    end
    check("reached_capture", cyc, cur_g + 1);
    #1 reset = 1'b0;
    req_a = 1'b0;
    #1 check_reset_values("mid");
    repeat (2) @(posedge clk);
    reset_model();
    #2 reset = 1'b1;
    repeat (4) step();
    run_op(1'b0, 1'b1, BASE + 8'd1, 8'hA5, 1'b0);
    run_op(1'b1, 1'b0, BASE + 8'd1, 8'h00, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
